// File: rtl/mul_pkg.sv
// Shared types and defaults for the execute-stage multiply controller.
package mul_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_MFHI  = 3'd3,
    OP_MFLO  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } mul_op_t;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} mul_state_t;

  localparam int MUL_LATENCY_DEF = 7;

endpackage

// File: rtl/e_mul_signfix.sv
// Conditional 64-bit two's-complement negate; used for operand magnitudes and result sign.
module e_mul_signfix (
  input  logic        neg,
  input  logic [63:0] data,
  output logic [63:0] result
);

  assign result = neg ? (~data + 64'd1) : data;

endmodule

// File: rtl/e_mul_ctrl.sv
// HI/LO owner and sequencer for the pipelined unsigned multiplier; one multiply in flight.
//   state | meaning
//   IDLE  | no multiply outstanding, all ops accepted
//   BUSY  | multiply in flight, every non-NOP op stalls
import mul_pkg::*;

module e_mul_ctrl #(
  parameter int MUL_LATENCY = MUL_LATENCY_DEF,
  parameter int CNT_W       = 3
) (
  input  logic        clock,
  input  logic        n_rst,
  input  logic        i_valid,
  input  logic [2:0]  i_op,
  input  logic [31:0] i_data_A,
  input  logic [31:0] i_data_B,
  output logic        o_stall,
  output logic        o_rd_valid,
  output logic [31:0] o_rd_data,
  output logic        o_mul_start,
  output logic [31:0] o_mul_A,
  output logic [31:0] o_mul_B,
  input  logic        i_mul_done,
  input  logic [31:0] i_mul_Hi,
  input  logic [31:0] i_mul_Lo,
  output logic        o_busy,
  output logic        o_err
);

  localparam logic [CNT_W-1:0] CNT_LAT = CNT_W'(MUL_LATENCY);

  mul_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             neg_flag, neg_nxt;
  logic             late, late_nxt;
  logic [31:0]      hi, lo, hi_nxt, lo_nxt;
  logic             rd_valid_nxt, err_nxt;
  logic [31:0]      rd_data_nxt;

  mul_op_t          op;
  logic             is_op, is_mul, accept, cnt_at_lat;
  logic             a_neg, b_neg;
  logic [63:0]      mag_a, mag_b, res;
  logic             unused_mag_hi;

  // Opcodes 0 and 7 fall through as NOP and never stall.
  always_comb begin
    op     = mul_op_t'(i_op);
    is_op  = 1'b0;
    is_mul = 1'b0;
    case (op)
      OP_MULT, OP_MULTU:                  begin is_op = 1'b1; is_mul = 1'b1; end
      OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO: is_op = 1'b1;
      default:                            ;
    endcase
  end

  assign o_stall     = i_valid && is_op && (state == BUSY);
  assign accept      = i_valid && is_op && (state == IDLE);
  assign o_mul_start = accept && is_mul;
  assign o_busy      = (state == BUSY);
  assign cnt_at_lat  = (cnt == CNT_LAT);

  assign a_neg = (op == OP_MULT) && i_data_A[31];
  assign b_neg = (op == OP_MULT) && i_data_B[31];

  e_mul_signfix u_mag_a (.neg(a_neg), .data({32'd0, i_data_A}), .result(mag_a));
  e_mul_signfix u_mag_b (.neg(b_neg), .data({32'd0, i_data_B}), .result(mag_b));
  e_mul_signfix u_res   (.neg(neg_flag), .data({i_mul_Hi, i_mul_Lo}), .result(res));

  assign o_mul_A       = mag_a[31:0];
  assign o_mul_B       = mag_b[31:0];
  assign unused_mag_hi = ^{mag_a[63:32], mag_b[63:32]};

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    neg_nxt      = neg_flag;
    late_nxt     = late;
    hi_nxt       = hi;
    lo_nxt       = lo;
    rd_valid_nxt = 1'b0;
    rd_data_nxt  = o_rd_data;
    err_nxt      = 1'b0;
    case (state)
      IDLE: begin
        if (i_mul_done) err_nxt = 1'b1;
        if (accept) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              state_nxt = BUSY;
              cnt_nxt   = CNT_W'(1);
              neg_nxt   = (op == OP_MULT) && (i_data_A[31] ^ i_data_B[31]);
              late_nxt  = 1'b0;
            end
            OP_MFHI: begin rd_valid_nxt = 1'b1; rd_data_nxt = hi; end
            OP_MFLO: begin rd_valid_nxt = 1'b1; rd_data_nxt = lo; end
            OP_MTHI: hi_nxt = i_data_A;
            OP_MTLO: lo_nxt = i_data_A;
            default: ;
          endcase
        end
      end
      BUSY: begin
        if (!cnt_at_lat) cnt_nxt = cnt + 1'b1;
        if (i_mul_done) begin
          {hi_nxt, lo_nxt} = res;
          state_nxt        = IDLE;
          if (!cnt_at_lat) err_nxt = 1'b1;
        end else if (cnt_at_lat && !late) begin
          // Report a missing done once, then keep waiting with the counter saturated.
          err_nxt  = 1'b1;
          late_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      cnt        <= '0;
      neg_flag   <= 1'b0;
      late       <= 1'b0;
      hi         <= '0;
      lo         <= '0;
      o_rd_valid <= 1'b0;
      o_rd_data  <= '0;
      o_err      <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      neg_flag   <= neg_nxt;
      late       <= late_nxt;
      hi         <= hi_nxt;
      lo         <= lo_nxt;
      o_rd_valid <= rd_valid_nxt;
      o_rd_data  <= rd_data_nxt;
      o_err      <= err_nxt;
    end
  end

endmodule

// File: tb/tb_e_mul_ctrl.sv
// Directed bench for e_mul_ctrl with a behavioural HI/LO model and a per-cycle compare process.
module tb_e_mul_ctrl;

  localparam int LAT = 7;

  logic        clock = 1'b0;
  logic        n_rst = 1'b0;
  logic        i_valid = 1'b0;
  logic [2:0]  i_op = 3'd0;
  logic [31:0] i_data_A = '0;
  logic [31:0] i_data_B = '0;
  logic        o_stall, o_rd_valid, o_mul_start, o_busy, o_err;
  logic [31:0] o_rd_data, o_mul_A, o_mul_B;
  logic        i_mul_done = 1'b0;
  logic [31:0] i_mul_Hi = '0;
  logic [31:0] i_mul_Lo = '0;

  int checks = 0;
  int failures = 0;
  int err_cnt = 0;

  always #5 clock = ~clock;

  e_mul_ctrl #(.MUL_LATENCY(LAT), .CNT_W(3)) dut (
    .clock(clock), .n_rst(n_rst), .i_valid(i_valid), .i_op(i_op),
    .i_data_A(i_data_A), .i_data_B(i_data_B), .o_stall(o_stall),
    .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data), .o_mul_start(o_mul_start),
    .o_mul_A(o_mul_A), .o_mul_B(o_mul_B), .i_mul_done(i_mul_done),
    .i_mul_Hi(i_mul_Hi), .i_mul_Lo(i_mul_Lo), .o_busy(o_busy), .o_err(o_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Architectural model: HI/LO, elapsed cycles of the outstanding multiply, signed product.
  bit          m_busy, m_rdv, m_err;
  int          m_t;
  logic [63:0] m_res;
  logic [31:0] m_hi, m_lo, m_rdd;

  always @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      m_busy <= 0; m_t <= 0; m_res <= '0; m_hi <= '0; m_lo <= '0;
      m_rdv <= 0; m_rdd <= '0; m_err <= 0;
    end else begin
      m_err <= (i_mul_done && (!m_busy || m_t < LAT)) || (m_busy && m_t == LAT && !i_mul_done);
      m_rdv <= 0;
      if (m_busy) begin
        m_t <= m_t + 1;
        if (i_mul_done) begin
          m_busy <= 0;
          {m_hi, m_lo} <= m_res;
        end
      end else if (i_valid) begin
        case (i_op)
          3'd1: begin
            m_busy <= 1; m_t <= 1;
            m_res <= $signed({{32{i_data_A[31]}}, i_data_A}) * $signed({{32{i_data_B[31]}}, i_data_B});
          end
          3'd2: begin
            m_busy <= 1; m_t <= 1;
            m_res <= {32'd0, i_data_A} * {32'd0, i_data_B};
          end
          3'd3: begin m_rdv <= 1; m_rdd <= m_hi; end
          3'd4: begin m_rdv <= 1; m_rdd <= m_lo; end
          3'd5: m_hi <= i_data_A;
          3'd6: m_lo <= i_data_A;
          default: ;
        endcase
      end
    end
  end

  always @(negedge clock) begin
    logic e_start;
    logic [31:0] ea, eb;
    e_start = i_valid && !m_busy && (i_op == 3'd1 || i_op == 3'd2);
    ea = (i_op == 3'd1 && i_data_A[31]) ? -i_data_A : i_data_A;
    eb = (i_op == 3'd1 && i_data_B[31]) ? -i_data_B : i_data_B;
    check("busy", o_busy, m_busy);
    check("stall", o_stall, i_valid && m_busy && i_op >= 3'd1 && i_op <= 3'd6);
    check("start", o_mul_start, e_start);
    check("err", o_err, m_err);
    check("rd_valid", o_rd_valid, m_rdv);
    if (m_rdv) check("rd_data", o_rd_data, m_rdd);
    if (e_start) begin
      check("mag_A", o_mul_A, ea);
      check("mag_B", o_mul_B, eb);
    end
    if (o_err) err_cnt++;
  end

  // Multiplier stand-in: done after done_delay cycles (0 = never), plus injected done pulses.
  bit          mm_active = 0, start_cap, last_stall, inj_done = 0;
  int          mm_cnt = 0, done_delay = LAT;
  logic [63:0] mm_prod = '0, prod_cap;

  task automatic tick();
    @(negedge clock);
    start_cap  = o_mul_start;
    prod_cap   = {32'd0, o_mul_A} * {32'd0, o_mul_B};
    last_stall = o_stall;
    @(posedge clock);
    #1;
    if (mm_active) mm_cnt++;
    if (start_cap) begin mm_active = 1; mm_cnt = 1; mm_prod = prod_cap; end
    i_mul_done = inj_done || (mm_active && done_delay != 0 && mm_cnt == done_delay);
    if (mm_active && mm_cnt == done_delay) mm_active = 0;
    {i_mul_Hi, i_mul_Lo} = mm_prod;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int stalls);
    i_valid = 1; i_op = op; i_data_A = a; i_data_B = b; stalls = 0;
    tick();
    while (last_stall && stalls < 40) begin stalls++; tick(); end
    if (last_stall) check("accept_timeout", 1, 0);
    i_valid = 0; i_op = 3'd0;
  endtask

  task automatic issue_mul(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] ea, input logic [31:0] eb);
    int s;
    i_valid = 1; i_op = op; i_data_A = a; i_data_B = b;
    #1;
    check("lit_start", o_mul_start, 1);
    check("lit_mul_A", o_mul_A, ea);
    check("lit_mul_B", o_mul_B, eb);
    issue(op, a, b, s);
  endtask

  task automatic read(input logic [2:0] op, input logic [31:0] exp);
    int s;
    issue(op, 0, 0, s);
    check("lit_rd_valid", o_rd_valid, 1);
    check("lit_rd_data", o_rd_data, exp);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (o_busy && n < 40) begin tick(); n++; end
    check("idle_timeout", o_busy, 0);
  endtask

  initial begin
    int s, e0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", o_busy, 0);
    check("rst_rd_valid", o_rd_valid, 0);
    check("rst_rd_data", o_rd_data, 0);
    check("rst_err", o_err, 0);
    n_rst = 1;
    tick();

    issue_mul(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_idle();
    read(3'd3, 32'hFFFFFFFE);
    read(3'd4, 32'h00000001);
    check("lit_no_err", err_cnt, 0);

    issue_mul(3'd1, 32'hFFFFFFFD, 32'd5, 32'd3, 32'd5);
    wait_idle();
    read(3'd3, 32'hFFFFFFFF);
    read(3'd4, 32'hFFFFFFF1);

    issue_mul(3'd1, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000);
    wait_idle();
    read(3'd3, 32'h40000000);
    read(3'd4, 32'h00000000);
    issue_mul(3'd1, 32'h80000000, 32'd1, 32'h80000000, 32'd1);
    wait_idle();
    read(3'd3, 32'hFFFFFFFF);
    read(3'd4, 32'h80000000);

    // MFHI held from cycle 1 stalls through the done cycle.
    issue_mul(3'd2, 32'h00010000, 32'h00030000, 32'h00010000, 32'h00030000);
    issue(3'd3, 0, 0, s);
    check("lit_mfhi_stalls", s, LAT);
    check("lit_mfhi_rd_valid", o_rd_valid, 1);
    check("lit_mfhi_data", o_rd_data, 32'h3);

    // NOP-class opcode during BUSY passes; a MULT is held until IDLE.
    issue_mul(3'd2, 32'd2, 32'd3, 32'd2, 32'd3);
    i_valid = 1; i_op = 3'd7;
    tick();
    check("lit_op7_nostall", last_stall, 0);
    issue(3'd1, 32'hFFFFFFFE, 32'd4, s);
    check("lit_mult_stalls", s, LAT - 1);
    wait_idle();
    read(3'd4, 32'hFFFFFFF8);
    read(3'd3, 32'hFFFFFFFF);

    issue(3'd6, 32'h12345678, 0, s);
    read(3'd4, 32'h12345678);
    issue(3'd5, 32'hCAFEF00D, 0, s);
    read(3'd3, 32'hCAFEF00D);

    // Asynchronous reset in the middle of a multiply.
    issue_mul(3'd2, 32'd2, 32'd3, 32'd2, 32'd3);
    tick();
    tick();
    #2;
    n_rst = 0; mm_active = 0; i_mul_done = 0;
    #1;
    check("lit_rst_busy", o_busy, 0);
    check("lit_rst_rd_valid", o_rd_valid, 0);
    tick();
    n_rst = 1;
    tick();
    read(3'd3, 32'h0);
    read(3'd4, 32'h0);

    // Stray done while IDLE.
    e0 = err_cnt;
    inj_done = 1;
    tick();
    inj_done = 0;
    tick();
    check("lit_idle_done_err", o_err, 1);
    tick();
    check("lit_idle_done_errcnt", err_cnt - e0, 1);
    read(3'd4, 32'h0);

    // Early done at cycle 5.
    done_delay = 5;
    e0 = err_cnt;
    issue_mul(3'd2, 32'd9, 32'd9, 32'd9, 32'd9);
    wait_idle();
    tick();
    check("lit_early_errcnt", err_cnt - e0, 1);
    read(3'd4, 32'd81);

    // Done never arrives: one error, stays BUSY until a late done.
    done_delay = 0;
    e0 = err_cnt;
    issue_mul(3'd2, 32'h100, 32'h100, 32'h100, 32'h100);
    repeat (12) tick();
    check("lit_hang_busy", o_busy, 1);
    check("lit_hang_errcnt", err_cnt - e0, 1);
    inj_done = 1;
    tick();
    inj_done = 0;
    wait_idle();
    tick();
    check("lit_late_errcnt", err_cnt - e0, 1);
    read(3'd4, 32'h00010000);
    read(3'd3, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
